// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: depth/pointer-width derivation and gray/binary conversion.
// Callers zero-extend narrower values to MaxW and slice the result back down.
package fifo_pkg;

  localparam int unsigned MaxW = 32;

  function automatic int unsigned fifo_depth(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

  // Pointers carry one extra bit to tell a full FIFO from an empty one.
  function automatic int unsigned ptr_w(input int unsigned addr_w);
    return addr_w + 32'd1;
  endfunction

  function automatic logic [MaxW-1:0] bin2gray(input logic [MaxW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [MaxW-1:0] gray2bin(input logic [MaxW-1:0] g);
    logic [MaxW-1:0] b;
    b[MaxW-1] = g[MaxW-1];
    for (int i = MaxW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// Combinational gray-to-binary converter; shared by the write- and read-side controllers.
// Each binary bit is the XOR of its gray bit and every more-significant gray bit.
module fifo_gray2bin #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] gray_i,
  output logic [W-1:0] bin_o
);

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign bin_o[i] = ^gray_i[W-1:i];
  end

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-domain controller for the async FIFO: binary/gray write pointer, fill level,
// registered full/almost-full flags and a sticky overflow flag.
module fifo_wr_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned AFULL_TH = 6
) (
  input  logic                w_clk,
  input  logic                w_rstn,
  input  logic                w_inc,
  input  logic                w_clr_ovf,
  input  logic [ADDR_W:0]     sync_rd_ptr,
  output logic                w_en,
  output logic [ADDR_W-1:0]   w_addr,
  output logic [ADDR_W:0]     gray_w_ptr,
  output logic                w_full,
  output logic                w_almost_full,
  output logic [ADDR_W:0]     w_level,
  output logic                w_overflow
);

  localparam int unsigned PtrW  = ptr_w(ADDR_W);
  localparam int unsigned Depth = fifo_depth(ADDR_W);

  logic [PtrW-1:0] w_ptr_q, w_ptr_d;
  logic [PtrW-1:0] gray_q, gray_d;
  logic [PtrW-1:0] level_q, level_d;
  logic [PtrW-1:0] rd_bin;
  logic            full_q, full_d;
  logic            afull_q, afull_d;
  logic            ovf_q, ovf_d;

  fifo_gray2bin #(
    .W (PtrW)
  ) u_rd_g2b (
    .gray_i (sync_rd_ptr),
    .bin_o  (rd_bin)
  );

  assign w_en = w_inc & ~full_q;

  always_comb begin
    w_ptr_d = w_ptr_q + PtrW'(w_en);
    gray_d  = PtrW'(bin2gray(MaxW'(w_ptr_d)));
    // Level uses the next write pointer so a write accepted this edge counts immediately.
    level_d = w_ptr_d - rd_bin;
    full_d  = (level_d == PtrW'(Depth));
    afull_d = (level_d >= PtrW'(AFULL_TH));
    ovf_d   = ovf_q;
    if (w_inc && full_q) begin
      ovf_d = 1'b1;
    end else if (w_clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge w_clk or negedge w_rstn) begin
    if (!w_rstn) begin
      w_ptr_q <= '0;
      gray_q  <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      w_ptr_q <= w_ptr_d;
      gray_q  <= gray_d;
      level_q <= level_d;
      full_q  <= full_d;
      afull_q <= afull_d;
      ovf_q   <= ovf_d;
    end
  end

  assign w_addr        = w_ptr_q[ADDR_W-1:0];
  assign gray_w_ptr    = gray_q;
  assign w_full        = full_q;
  assign w_almost_full = afull_q;
  assign w_level       = level_q;
  assign w_overflow    = ovf_q;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Self-checking bench for fifo_wr_ctrl (ADDR_W=3): directed scenarios then random traffic,
// checked against a count-based model of accepted writes and read progress.
module tb_fifo_wr_ctrl;

  logic       w_clk = 1'b0;
  logic       w_rstn;
  logic       w_inc;
  logic       w_clr_ovf;
  logic [3:0] sync_rd_ptr;
  logic       w_en;
  logic [2:0] w_addr;
  logic [3:0] gray_w_ptr;
  logic       w_full;
  logic       w_almost_full;
  logic [3:0] w_level;
  logic       w_overflow;

  int checks = 0;
  int errors = 0;

  // Model: total accepted writes, total reads seen, and registered flag expectations.
  int exp_wr  = 0;
  int rd_cnt  = 0;
  int exp_lvl = 0;
  bit exp_full = 0;
  bit exp_af   = 0;
  bit exp_ovf  = 0;

  fifo_wr_ctrl #(
    .ADDR_W   (3),
    .AFULL_TH (6)
  ) dut (
    .w_clk         (w_clk),
    .w_rstn        (w_rstn),
    .w_inc         (w_inc),
    .w_clr_ovf     (w_clr_ovf),
    .sync_rd_ptr   (sync_rd_ptr),
    .w_en          (w_en),
    .w_addr        (w_addr),
    .gray_w_ptr    (gray_w_ptr),
    .w_full        (w_full),
    .w_almost_full (w_almost_full),
    .w_level       (w_level),
    .w_overflow    (w_overflow)
  );

  always #5 w_clk = ~w_clk;

  function automatic logic [3:0] to_gray(input int n);
    int m;
    m = n % 16;
    return 4'(m ^ (m >> 1));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, "_gray"},  32'(gray_w_ptr),    32'(to_gray(exp_wr)));
    chk({tag, "_level"}, 32'(w_level),       32'(exp_lvl));
    chk({tag, "_full"},  32'(w_full),        32'(exp_full));
    chk({tag, "_afull"}, 32'(w_almost_full), 32'(exp_af));
    chk({tag, "_ovf"},   32'(w_overflow),    32'(exp_ovf));
  endtask

  task automatic model_reset();
    exp_wr = 0; rd_cnt = 0; exp_lvl = 0;
    exp_full = 0; exp_af = 0; exp_ovf = 0;
  endtask

  // One write-clock cycle: drive at negedge, check strobe/address, then check registers.
  task automatic cycle(input string tag, input bit inc, input bit clr, input int rd);
    bit acc;
    @(negedge w_clk);
    w_inc       = inc;
    w_clr_ovf   = clr;
    rd_cnt      = rd;
    sync_rd_ptr = to_gray(rd);
    #1;
    acc = inc && !exp_full;
    chk({tag, "_en"},   32'(w_en),   32'(acc));
    chk({tag, "_addr"}, 32'(w_addr), 32'(exp_wr % 8));
    @(posedge w_clk);
    if (inc && exp_full) exp_ovf = 1;
    else if (clr)        exp_ovf = 0;
    if (acc) exp_wr++;
    exp_lvl  = (exp_wr - rd_cnt) % 16;
    exp_full = (exp_lvl == 8);
    exp_af   = (exp_lvl >= 6);
    #1;
    chk_regs(tag);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_en"},    32'(w_en),          0);
    chk({tag, "_addr"},  32'(w_addr),        0);
    chk({tag, "_gray"},  32'(gray_w_ptr),    0);
    chk({tag, "_level"}, 32'(w_level),       0);
    chk({tag, "_full"},  32'(w_full),        0);
    chk({tag, "_afull"}, 32'(w_almost_full), 0);
    chk({tag, "_ovf"},   32'(w_overflow),    0);
  endtask

  initial begin
    int rd;
    w_rstn = 1'b0; w_inc = 1'b0; w_clr_ovf = 1'b0; sync_rd_ptr = '0;

    // T1: reset and idle after release.
    repeat (3) @(posedge w_clk);
    #1 chk_all_zero("t1_rst");
    @(negedge w_clk) w_rstn = 1'b1;
    for (int i = 0; i < 3; i++) cycle("t1_idle", 0, 0, 0);

    // T2: fill with eight back-to-back writes.
    for (int i = 0; i < 8; i++) cycle("t2_fill", 1, 0, 0);
    chk("t2_full_gray", 32'(gray_w_ptr), 32'h0000000C);
    chk("t2_full_flag", 32'(w_full), 1);

    // T3: overflow, clear, then set-beats-clear.
    cycle("t3_ovf", 1, 0, 0);
    chk("t3_ovf_set", 32'(w_overflow), 1);
    cycle("t3_clr", 0, 1, 0);
    chk("t3_ovf_clr", 32'(w_overflow), 0);
    cycle("t3_both", 1, 1, 0);
    chk("t3_ovf_prio", 32'(w_overflow), 1);
    cycle("t3_clr2", 0, 1, 0);

    // T4: read progress from full.
    cycle("t4_rd2", 0, 0, 2);
    chk("t4_lvl6", 32'(w_level), 6);
    cycle("t4_rd3", 0, 0, 3);
    chk("t4_lvl5", 32'(w_level), 5);
    chk("t4_af0", 32'(w_almost_full), 0);

    // T5: stream 20 writes with the reader just behind so the level sits at 2.
    for (int i = 0; i < 20; i++) begin
      cycle("t5_wrap", 1, 0, exp_wr - 1);
      chk("t5_lvl2", 32'(w_level), 2);
    end

    // T6: fill, overflow, then asynchronous reset mid-cycle.
    rd = rd_cnt;
    for (int i = 0; i < 10; i++) cycle("t6_fill", 1, 0, rd);
    chk("t6_full", 32'(w_full), 1);
    chk("t6_ovf", 32'(w_overflow), 1);
    #2;
    w_inc = 1'b0;
    w_rstn = 1'b0;
    #1 chk_all_zero("t6_async");
    model_reset();
    sync_rd_ptr = '0;
    @(negedge w_clk) w_rstn = 1'b1;
    cycle("t6_post", 1, 0, 0);
    chk("t6_lvl1", 32'(w_level), 1);

    // Random traffic: reads never pass committed writes, as with a real reader.
    for (int i = 0; i < 400; i++) begin
      bit inc, clr;
      rd = rd_cnt;
      inc = ($urandom_range(0, 99) < 65);
      clr = ($urandom_range(0, 99) < 10);
      if (rd < exp_wr && $urandom_range(0, 99) < 45) rd++;
      cycle("rnd", inc, clr, rd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
